// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: payload field layout, bubble constants and
// a helper that builds the idle payload for each inter-stage register.
package pipe_pkg;

    localparam int STAGE_W = 200;

    localparam logic [7:0] ALUOP_NOP = 8'h11;
    localparam logic [4:0] EXC_NONE  = 5'h10;

    // Low-order fields common to the ID/EXE, EXE/MEM and MEM/WB payloads
    localparam int ALUOP_LSB = 0;
    localparam int ALUOP_W   = 8;
    localparam int EXC_LSB   = ALUOP_LSB + ALUOP_W;
    localparam int EXC_W     = 5;
    localparam int PC_LSB    = EXC_LSB + EXC_W;
    localparam int PC_W      = 32;

    typedef enum logic [1:0] {
        STG_IF_ID   = 2'd0,
        STG_ID_EXE  = 2'd1,
        STG_EXE_MEM = 2'd2,
        STG_MEM_WB  = 2'd3
    } stage_e;

    // IF/ID carries no decoded fields, so its bubble stays all-zero.
    function automatic logic [STAGE_W-1:0] bubble_val(input stage_e stg);
        logic [STAGE_W-1:0] b;
        b = '0;
        if (stg == STG_ID_EXE)
            b[ALUOP_LSB +: ALUOP_W] = ALUOP_NOP;
        if (stg != STG_IF_ID)
            b[EXC_LSB +: EXC_W] = EXC_NONE;
        return b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running up-counter that sticks at all-ones; cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid slot,
// so in_ready comes straight from a flop. Idle payload is forced to BUBBLE_VAL.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = STAGE_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = ~skid_valid;
    assign in_fire   = in_valid & ~skid_valid;
    assign out_fire  = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // in_data is only sampled on in_fire, so garbage on an idle bus never lands in main/skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= BUBBLE_VAL;
            skid_data  <= BUBBLE_VAL;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= BUBBLE_VAL;
            skid_data  <= BUBBLE_VAL;
        end else if (skid_valid) begin
            if (out_fire) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_data  <= BUBBLE_VAL;
            end
        end else if (main_valid) begin
            if (in_fire && out_fire) begin
                main_data <= in_data;
            end else if (in_fire) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end else if (out_fire) begin
                main_valid <= 1'b0;
                main_data  <= BUBBLE_VAL;
            end
        end else if (in_fire) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~main_valid & out_ready),
        .cnt   (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomized checks of pipe_skid_stage (8-bit payload, bubble A5).
module tb_pipe_skid_stage;

    localparam int         DW  = 8;
    localparam logic [7:0] BUB = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   bubble_cnt;

    logic          rst2_n = 1'b0;
    logic          in_ready2;
    logic          out_valid2;
    logic [DW-1:0] out_data2;
    logic [1:0]    occupancy2;
    logic [2:0]    bubble_cnt2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    // Small-counter instance idles with downstream ready to exercise saturation
    pipe_skid_stage #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .flush(1'b0),
        .in_valid(1'b0), .in_ready(in_ready2), .in_data(8'h00),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .occupancy(occupancy2), .bubble_cnt(bubble_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    logic [7:0] q[$];
    logic [7:0] d;
    bit         iv, ordy, fl;
    int         exp_size;

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'hA5);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_bubble", 32'(bubble_cnt), 32'd0);
        step();
        rst_n = 1'b1;

        // Seven idle cycles with downstream ready
        out_ready = 1'b1;
        repeat (7) step();
        chk("bubble_7", 32'(bubble_cnt), 32'd7);

        // Async reset drops a held payload immediately
        out_ready = 1'b0;
        push(8'h5A);
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_data", 32'(out_data), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'hA5);
        chk("async_rst_bubble", 32'(bubble_cnt), 32'd0);
        step();
        rst_n = 1'b1;

        // Streaming 01..10 with downstream always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        in_data  = 8'hFF;
        step();
        chk("stream_end_valid", 32'(out_valid), 32'd0);
        chk("stream_end_data", 32'(out_data), 32'hA5);

        // Back-pressure: 33 must wait upstream until a slot frees
        out_ready = 1'b0;
        push(8'h11);
        chk("bp_occ1", 32'(occupancy), 32'd1);
        push(8'h22);
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        push(8'h33);
        chk("bp_hold_occ", 32'(occupancy), 32'd2);
        chk("bp_hold_data", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        step();
        chk("bp_rel_22", 32'(out_data), 32'h22);
        chk("bp_rel_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_rel_33", 32'(out_data), 32'h33);
        in_valid = 1'b0;
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush in FULL with an offered 44
        out_ready = 1'b0;
        push(8'hAA);
        push(8'hBB);
        chk("fl_full_occ", 32'(occupancy), 32'd2);
        in_valid = 1'b1;
        in_data  = 8'h44;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_full_valid", 32'(out_valid), 32'd0);
        chk("fl_full_data", 32'(out_data), 32'hA5);
        chk("fl_full_occ0", 32'(occupancy), 32'd0);
        chk("fl_full_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl_full_lost", 32'(out_valid), 32'd0);

        // Flush in ONE while an accepted beat arrives: that beat is discarded too
        out_ready = 1'b0;
        push(8'hCC);
        in_data = 8'h44;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_one_occ", 32'(occupancy), 32'd0);
        out_ready = 1'b1;
        step();
        chk("fl_one_lost", 32'(out_valid), 32'd0);
        chk("fl_one_data", 32'(out_data), 32'hA5);

        // Randomized traffic against a FIFO scoreboard
        out_ready = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            exp_size = q.size();
            chk("rnd_occ", 32'(occupancy), 32'(exp_size));
            chk("rnd_valid", 32'(out_valid), 32'(exp_size != 0));
            chk("rnd_ready", 32'(in_ready), 32'(exp_size < 2));
            if (exp_size != 0) chk("rnd_data", 32'(out_data), 32'(q[0]));
            else               chk("rnd_bubble", 32'(out_data), 32'hA5);
            iv   = ($urandom_range(3) != 0);
            ordy = ($urandom_range(2) != 0);
            fl   = ($urandom_range(63) == 0);
            d    = 8'($urandom);
            in_valid  = iv;
            in_data   = iv ? d : 8'($urandom);
            out_ready = ordy;
            flush     = fl;
            if (fl) begin
                q.delete();
            end else begin
                if (ordy && exp_size != 0) void'(q.pop_front());
                if (iv && exp_size < 2) q.push_back(d);
            end
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        // Saturating counter instance: 3 cycles then 10 total
        rst2_n = 1'b1;
        repeat (3) step();
        chk("sat_cnt_3", 32'(bubble_cnt2), 32'd3);
        repeat (7) step();
        chk("sat_cnt_10", 32'(bubble_cnt2), 32'd7);
        chk("sat_idle_data", 32'(out_data2), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
